// File: rtl/washer_panel_if.sv
// Signal bundle between the washer front panel and its environment: raw panel and
// controller inputs, the controller-facing outputs, and the FSM state for observation.
// Handshake: there is no valid/ready flow; o_start, o_cancel and o_refund are
// single-cycle strobes, all other outputs are registered levels.
interface washer_panel_if;
  logic       i_btn_start;
  logic       i_btn_cancel;
  logic       i_btn_mode;
  logic       i_coin_sense;
  logic       i_done;
  logic       i_coinreturn;
  logic       o_coin;
  logic       o_start;
  logic       o_cancel;
  logic       o_mode_1;
  logic       o_mode_2;
  logic       o_mode_3;
  logic [1:0] o_mode_sel;
  logic [3:0] o_credit;
  logic       o_refund;
  logic [1:0] dbg_state;

  modport master (
    output i_btn_start, i_btn_cancel, i_btn_mode, i_coin_sense, i_done, i_coinreturn,
    input  o_coin, o_start, o_cancel, o_mode_1, o_mode_2, o_mode_3,
    input  o_mode_sel, o_credit, o_refund, dbg_state
  );

  modport slave (
    input  i_btn_start, i_btn_cancel, i_btn_mode, i_coin_sense, i_done, i_coinreturn,
    output o_coin, o_start, o_cancel, o_mode_1, o_mode_2, o_mode_3,
    output o_mode_sel, o_credit, o_refund, dbg_state
  );
endinterface

// File: rtl/washer_panel.sv
// Washer front panel: synchronises and debounces buttons and coin sensor, keeps
// coin credit against PRICE, selects wash mode and pays out refunds coin by coin.
module washer_panel #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int PRICE           = 3,
  parameter int REFUND_GAP      = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  washer_panel_if.slave bus
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int GW = (REFUND_GAP > 1) ? $clog2(REFUND_GAP) : 1;
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(REFUND_GAP - 1);
  localparam logic [3:0]    PRICE4   = 4'(PRICE);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_PAID   = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_REFUND = 2'd3;

  localparam int EV_START = 0, EV_CANCEL = 1, EV_MODE = 2, EV_COIN = 3;

  logic [3:0]         raw;
  logic [3:0]         sync1_q, sync2_q, deb_q, deb_d, ev_q, ev_d;
  logic [3:0][CW-1:0] cnt_q, cnt_d;

  logic [1:0]    state_q, state_d;
  logic [3:0]    credit_q, credit_d, cred_inc, rem;
  logic [1:0]    mode_q, mode_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          coin_q, coin_d, start_q, start_d, cancel_q, cancel_d, refund_q, refund_d;
  logic [2:0]    modes_q, modes_d;
  logic          coin_ok, fire, run_hold;

  assign raw = {bus.i_coin_sense, bus.i_btn_mode, bus.i_btn_cancel, bus.i_btn_start};

  // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      cnt_d[i] = '0;
      deb_d[i] = deb_q[i];
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == DEB_LAST) deb_d[i] = sync2_q[i];
        else                      cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
    ev_d = deb_d & ~deb_q;
  end

  always_comb begin
    coin_ok  = ev_q[EV_COIN] && (state_q != S_REFUND) && (credit_q != 4'hF);
    cred_inc = credit_q + {3'b000, coin_ok};
    rem      = cred_inc - PRICE4;
    state_d  = state_q;
    credit_d = cred_inc;
    mode_d   = mode_q;
    start_d  = 1'b0;
    cancel_d = 1'b0;
    if (ev_q[EV_MODE] && (state_q == S_IDLE || state_q == S_PAID))
      mode_d = (mode_q == 2'd3) ? 2'd1 : mode_q + 2'd1;
    case (state_q)
      S_IDLE: begin
        if (bus.i_coinreturn)                          state_d = S_REFUND;
        else if (ev_q[EV_CANCEL] && cred_inc != 4'd0)  state_d = S_REFUND;
        else if (credit_q >= PRICE4)                   state_d = S_PAID;
      end
      S_PAID: begin
        if (bus.i_coinreturn) state_d = S_REFUND;
        else if (ev_q[EV_CANCEL]) begin
          state_d  = S_REFUND;
          cancel_d = 1'b1;
        end else if (ev_q[EV_START]) begin
          state_d = S_RUN;
          start_d = 1'b1;
        end
      end
      S_RUN: begin
        if (bus.i_coinreturn) state_d = S_REFUND;
        else if (bus.i_done || ev_q[EV_CANCEL]) begin
          // Cancelling a running cycle forfeits its price just like completing it.
          cancel_d = !bus.i_done;
          credit_d = rem;
          state_d  = (rem >= PRICE4) ? S_PAID : S_IDLE;
        end
      end
      default: begin
        if (credit_q == 4'd0) state_d = S_IDLE;
      end
    endcase

    // The first coin is ejected on entry, then one every REFUND_GAP cycles.
    fire     = (state_d == S_REFUND) && (credit_d != 4'd0) &&
               ((state_q != S_REFUND) || (gap_q == GAP_LAST));
    refund_d = fire;
    gap_d    = gap_q;
    if (fire) begin
      credit_d = credit_d - 4'd1;
      gap_d    = '0;
    end else if (state_q == S_REFUND && gap_q != GAP_LAST) begin
      gap_d = gap_q + GW'(1);
    end

    coin_d   = !(state_d == S_PAID || state_d == S_RUN);
    run_hold = (state_q == S_RUN) && (state_d == S_RUN);
    modes_d  = {run_hold && mode_q == 2'd3, run_hold && mode_q == 2'd2,
                run_hold && mode_q == 2'd1};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      ev_q     <= '0;
      state_q  <= S_IDLE;
      credit_q <= '0;
      mode_q   <= 2'd1;
      gap_q    <= '0;
      coin_q   <= 1'b1;
      start_q  <= 1'b0;
      cancel_q <= 1'b0;
      refund_q <= 1'b0;
      modes_q  <= '0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      ev_q     <= ev_d;
      state_q  <= state_d;
      credit_q <= credit_d;
      mode_q   <= mode_d;
      gap_q    <= gap_d;
      coin_q   <= coin_d;
      start_q  <= start_d;
      cancel_q <= cancel_d;
      refund_q <= refund_d;
      modes_q  <= modes_d;
    end
  end

  assign bus.o_coin     = coin_q;
  assign bus.o_start    = start_q;
  assign bus.o_cancel   = cancel_q;
  assign bus.o_mode_1   = modes_q[0];
  assign bus.o_mode_2   = modes_q[1];
  assign bus.o_mode_3   = modes_q[2];
  assign bus.o_mode_sel = mode_q;
  assign bus.o_credit   = credit_q;
  assign bus.o_refund   = refund_q;
  assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_washer_panel.sv
// Bench for washer_panel: directed purchase/refund/bounce/reset scenarios plus random
// panel activity, compared against a transaction-level model of the washer rules.
module tb_washer_panel;
  localparam int DEB    = 4;
  localparam int PRICE  = 3;
  localparam int GAP    = 2;
  localparam int HOLD   = DEB + 8;
  localparam int SETTLE = 40;

  localparam int S_IDLE = 0, S_PAID = 1, S_RUN = 2, S_REFUND = 3;
  localparam int A_COIN = 0, A_MODE = 1, A_START = 2, A_CANCEL = 3,
                 A_DONE = 4, A_CRET = 5, A_BOUNCE = 6;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  washer_panel_if bus ();

  washer_panel #(
    .DEBOUNCE_CYCLES(DEB),
    .PRICE          (PRICE),
    .REFUND_GAP     (GAP)
  ) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .bus  (bus)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  int m_state, m_credit, m_mode;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // output monitor, sampled on the falling edge
  int cyc = 0, tot_start = 0, tot_cancel = 0, tot_refund = 0, gap_err = 0;
  int last_ref = -100, reach_cyc = -100, coin_fall_cyc = -100;
  int start_cyc = -100, mode_rise_cyc = -100;
  logic       prev_coin = 1'b1, prev_mode_any = 1'b0;
  logic [3:0] prev_credit = 4'd0;
  logic       mode_any;
  assign mode_any = bus.o_mode_1 | bus.o_mode_2 | bus.o_mode_3;

  always @(negedge i_clk) begin
    cyc++;
    if (bus.o_start === 1'b1) begin tot_start++; start_cyc = cyc; end
    if (bus.o_cancel === 1'b1) tot_cancel++;
    if (bus.o_refund === 1'b1) begin
      tot_refund++;
      if (cyc - last_ref < 20 && cyc - last_ref != GAP) gap_err++;
      last_ref = cyc;
    end
    if (int'(prev_credit) < PRICE && int'(bus.o_credit) >= PRICE) reach_cyc = cyc;
    if (prev_coin && !bus.o_coin) coin_fall_cyc = cyc;
    if (!prev_mode_any && mode_any) mode_rise_cyc = cyc;
    prev_coin     = bus.o_coin;
    prev_credit   = bus.o_credit;
    prev_mode_any = mode_any;
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic set_raw(input int a, input logic v);
    case (a)
      A_START:  bus.i_btn_start  = v;
      A_CANCEL: bus.i_btn_cancel = v;
      A_MODE:   bus.i_btn_mode   = v;
      default:  bus.i_coin_sense = v;
    endcase
  endtask

  task automatic drive(input int a);
    if (a == A_DONE || a == A_CRET) begin
      if (a == A_DONE) bus.i_done = 1'b1; else bus.i_coinreturn = 1'b1;
      tick(1);
      bus.i_done = 1'b0;
      bus.i_coinreturn = 1'b0;
      tick(2 * HOLD - 1);
    end else if (a == A_BOUNCE) begin
      for (int i = 0; i < 10; i++) begin
        bus.i_coin_sense = ~bus.i_coin_sense;
        tick(1);
      end
      bus.i_coin_sense = 1'b1;
      tick(8);
      bus.i_coin_sense = 1'b0;
      tick(2 * HOLD - 18);
    end else begin
      set_raw(a, 1'b1);
      tick(HOLD);
      set_raw(a, 1'b0);
      tick(HOLD);
    end
    tick(SETTLE);
  endtask

  task automatic model_reset();
    m_state  = S_IDLE;
    m_credit = 0;
    m_mode   = 1;
  endtask

  task automatic do_action(input int a);
    int e_start = 0, e_cancel = 0, e_refund = 0;
    bit want_coin_lag = 0, want_mode_lag = 0;
    int s0, c0, r0, g0, t0;
    case (a)
      A_COIN, A_BOUNCE:
        if (m_state != S_REFUND) begin
          if (m_credit < 15) m_credit++;
          if (m_state == S_IDLE && m_credit >= PRICE) begin
            m_state = S_PAID;
            want_coin_lag = 1;
          end
        end
      A_MODE:
        if (m_state == S_IDLE || m_state == S_PAID) m_mode = (m_mode % 3) + 1;
      A_START:
        if (m_state == S_PAID) begin
          m_state = S_RUN;
          e_start = 1;
          want_mode_lag = 1;
        end
      A_CANCEL:
        if (m_state == S_IDLE) begin
          e_refund = m_credit;
          m_credit = 0;
        end else if (m_state == S_PAID) begin
          e_cancel = 1;
          e_refund = m_credit;
          m_credit = 0;
          m_state  = S_IDLE;
        end else if (m_state == S_RUN) begin
          e_cancel = 1;
          m_credit = m_credit - PRICE;
          m_state  = (m_credit >= PRICE) ? S_PAID : S_IDLE;
        end
      A_DONE:
        if (m_state == S_RUN) begin
          m_credit = m_credit - PRICE;
          m_state  = (m_credit >= PRICE) ? S_PAID : S_IDLE;
        end
      default: begin
        e_refund = m_credit;
        m_credit = 0;
        m_state  = S_IDLE;
      end
    endcase
    exp_q.push_back(8'(e_start));
    exp_q.push_back(8'(e_cancel));
    exp_q.push_back(8'(e_refund));
    exp_q.push_back(8'(m_credit));
    exp_q.push_back(8'(m_mode));
    exp_q.push_back(8'((m_state == S_PAID || m_state == S_RUN) ? 0 : 1));
    exp_q.push_back(8'((m_state == S_RUN) ? (1 << (m_mode - 1)) : 0));
    exp_q.push_back(8'(m_state));

    s0 = tot_start; c0 = tot_cancel; r0 = tot_refund; g0 = gap_err; t0 = cyc;
    drive(a);

    check("start_pulses",  tot_start - s0,  exp_q.pop_front());
    check("cancel_pulses", tot_cancel - c0, exp_q.pop_front());
    check("refund_pulses", tot_refund - r0, exp_q.pop_front());
    check("credit",        bus.o_credit,    exp_q.pop_front());
    check("mode_sel",      bus.o_mode_sel,  exp_q.pop_front());
    check("coin_n",        bus.o_coin,      exp_q.pop_front());
    check("mode_onehot",   {bus.o_mode_3, bus.o_mode_2, bus.o_mode_1}, exp_q.pop_front());
    check("state",         bus.dbg_state,   exp_q.pop_front());
    check("refund_gap",    gap_err - g0,    0);
    if (want_coin_lag)
      check("coin_fall_lag", (coin_fall_cyc > t0) ? coin_fall_cyc - reach_cyc : -1, 1);
    if (want_mode_lag)
      check("mode_after_start", (mode_rise_cyc > t0) ? mode_rise_cyc - start_cyc : -1, 1);
  endtask

  task automatic apply_reset();
    i_rst = 1'b1;
    tick(2);
    i_rst = 1'b0;
    model_reset();
  endtask

  task automatic check_reset_outputs();
    check("rst_coin",   bus.o_coin,     1);
    check("rst_credit", bus.o_credit,   0);
    check("rst_mode",   bus.o_mode_sel, 1);
    check("rst_start",  bus.o_start,    0);
    check("rst_cancel", bus.o_cancel,   0);
    check("rst_refund", bus.o_refund,   0);
    check("rst_modes",  {bus.o_mode_3, bus.o_mode_2, bus.o_mode_1}, 0);
    check("rst_state",  bus.dbg_state,  S_IDLE);
  endtask

  initial begin
    int r0, k, r;
    bus.i_btn_start  = 1'b0;
    bus.i_btn_cancel = 1'b0;
    bus.i_btn_mode   = 1'b0;
    bus.i_coin_sense = 1'b0;
    bus.i_done       = 1'b0;
    bus.i_coinreturn = 1'b0;
    #1;
    apply_reset();
    check_reset_outputs();

    // purchase, mode select, run and completion
    repeat (3) do_action(A_COIN);
    repeat (2) do_action(A_MODE);
    do_action(A_START);
    do_action(A_DONE);

    // bounce on the coin sensor yields one coin
    do_action(A_BOUNCE);
    do_action(A_COIN);
    do_action(A_CANCEL);
    do_action(A_CANCEL);

    // cancel during a run with surplus credit
    repeat (5) do_action(A_COIN);
    do_action(A_START);
    do_action(A_CANCEL);
    do_action(A_CRET);

    // saturation, then reset in the middle of a refund
    repeat (17) do_action(A_COIN);
    r0 = tot_refund;
    bus.i_btn_cancel = 1'b1;
    for (k = 0; k < 80; k++) begin
      if (tot_refund - r0 >= 3) break;
      tick(1);
    end
    check("rst_wait_refund3", (tot_refund - r0 >= 3) ? 1 : 0, 1);
    i_rst = 1'b1;
    tick(2);
    i_rst = 1'b0;
    bus.i_btn_cancel = 1'b0;
    model_reset();
    r0 = tot_refund;
    check_reset_outputs();
    tick(2 * HOLD + SETTLE);
    check("post_rst_refunds", tot_refund - r0, 0);
    check("post_rst_credit",  bus.o_credit,    0);
    check("post_rst_state",   bus.dbg_state,   S_IDLE);

    // random panel activity
    for (int n = 0; n < 120; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 35) do_action(A_COIN);
      else if (r < 50) do_action(A_MODE);
      else if (r < 65) do_action(A_START);
      else if (r < 78) do_action(A_CANCEL);
      else if (r < 92) do_action(A_DONE);
      else             do_action(A_CRET);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
